// File: rtl/store_buffer.sv
// Posted-write buffer between the memory stage and data memory: queues stores,
// gives loads priority, and holds loads that hit a queued store's word.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_write_data,
  input  logic        cpu_memwrite,
  input  logic        cpu_memread,
  input  logic [3:0]  cpu_sign_mask,
  output logic [31:0] cpu_read_data,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_sign_mask,
  output logic        mem_memwrite,
  output logic        mem_memread,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall,
  output logic        drained
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // state   | meaning
  // M_IDLE  | no transaction outstanding
  // ISSUE   | request pulse on mem_memread / mem_memwrite
  // WAIT_HI | waiting for data memory to raise mem_clk_stall
  // WAIT_LO | waiting for mem_clk_stall to fall (transaction complete)
  typedef enum logic [1:0] {M_IDLE, ISSUE, WAIT_HI, WAIT_LO} mstate_t;

  mstate_t state, state_nxt;

  logic [31:0]   fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [3:0]    fifo_mask [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic op_read, load_done;
  logic hazard, can_dispatch, complete, load_busy;
  logic load_go, pop, push, write_req;

  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) &&
          (fifo_addr[rd_ptr + PW'(k)][31:2] == cpu_addr[31:2]))
        hazard = 1'b1;
    end
  end

  // A read that has been issued stays blocked from re-dispatch until its data returns.
  assign load_busy    = op_read & (state != M_IDLE);
  assign complete     = (state == WAIT_LO) & ~mem_clk_stall;
  assign can_dispatch = ~mem_clk_stall & ((state == M_IDLE) | (state == WAIT_LO));
  assign load_go      = can_dispatch & cpu_memread & ~load_done & ~load_busy & ~hazard;
  assign pop          = can_dispatch & ~load_go & (count != '0);
  assign write_req    = cpu_memwrite & ~cpu_memread;
  assign push         = write_req & ((count != CW'(DEPTH)) | pop);
  assign cpu_stall    = (write_req & ~push) | (cpu_memread & ~load_done);
  assign drained      = (count == '0) & (state == M_IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      M_IDLE:  if (load_go | pop) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT_HI;
      WAIT_HI: if (mem_clk_stall) state_nxt = WAIT_LO;
      WAIT_LO: if (!mem_clk_stall) state_nxt = (load_go | pop) ? ISSUE : M_IDLE;
      default: state_nxt = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= M_IDLE;
      op_read        <= 1'b0;
      load_done      <= 1'b0;
      cpu_read_data  <= '0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_sign_mask  <= '0;
      mem_memwrite   <= 1'b0;
      mem_memread    <= 1'b0;
    end else begin
      state        <= state_nxt;
      load_done    <= complete & op_read;
      mem_memread  <= load_go;
      mem_memwrite <= pop;
      if (load_go) begin
        mem_addr       <= cpu_addr;
        mem_write_data <= cpu_write_data;
        mem_sign_mask  <= cpu_sign_mask;
        op_read        <= 1'b1;
      end else if (pop) begin
        mem_addr       <= fifo_addr[rd_ptr];
        mem_write_data <= fifo_data[rd_ptr];
        mem_sign_mask  <= fifo_mask[rd_ptr];
        op_read        <= 1'b0;
      end
      if (complete && op_read)
        cpu_read_data <= mem_read_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage needs no reset: validity is tracked by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cpu_addr;
      fifo_data[wr_ptr] <= cpu_write_data;
      fifo_mask[wr_ptr] <= cpu_sign_mask;
    end
  end

endmodule
